// File: rtl/calendar_date_month.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | calendar_date_month: date (1..31) / month (1..12) / leap-phase stage  |
// | advanced by the day rollover tick or by manual set inputs.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module calendar_date_month #(
  parameter bit LEAP_EN    = 1'b1,
  parameter int INIT_MONTH = 1,
  parameter int INIT_DATE  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       day_tick,
  input  logic       timeset,
  input  logic       date_adv,
  input  logic       month_adv,
  input  logic       year_adv,
  output logic [6:0] TDate,
  output logic [6:0] TMonth,
  output logic [1:0] yr_phase,
  output logic       leap,
  output logic       year_tick
);

  localparam logic [6:0] c_JAN = 7'd1;
  localparam logic [6:0] c_FEB = 7'd2;
  localparam logic [6:0] c_DEC = 7'd12;

  logic [6:0] r_date, r_month;
  logic [1:0] r_phase;
  logic       r_ytick;

  logic [6:0] w_date, w_month;
  logic [1:0] w_phase, w_phase_inc;
  logic       w_ytick;
  logic [6:0] w_month_inc, w_dim_cur, w_dim_month_inc, w_dim_feb_next;

  function automatic logic [6:0] f_dim(input logic [6:0] m, input logic lp);
    case (m)
      7'd2:                    f_dim = lp ? 7'd29 : 7'd28;
      7'd4, 7'd6, 7'd9, 7'd11: f_dim = 7'd30;
      default:                 f_dim = 7'd31;
    endcase
  endfunction

  assign leap            = LEAP_EN & (r_phase == 2'd0);
  assign w_phase_inc     = r_phase + 2'd1;
  assign w_month_inc     = (r_month == c_DEC) ? c_JAN : r_month + 7'd1;
  assign w_dim_cur       = f_dim(r_month, leap);
  assign w_dim_month_inc = f_dim(w_month_inc, leap);
  // February length once the leap phase has stepped forward
  assign w_dim_feb_next  = f_dim(c_FEB, LEAP_EN & (w_phase_inc == 2'd0));

  always_comb begin
    w_date  = r_date;
    w_month = r_month;
    w_phase = r_phase;
    w_ytick = 1'b0;
    if (day_tick) begin
      if (r_date < w_dim_cur) begin
        w_date = r_date + 7'd1;
      end else begin
        w_date = c_JAN;
        if (r_month < c_DEC) begin
          w_month = r_month + 7'd1;
        end else begin
          w_month = c_JAN;
          w_phase = w_phase_inc;
          w_ytick = 1'b1;
        end
      end
    end else if (timeset && month_adv) begin
      w_month = w_month_inc;
      if (r_date > w_dim_month_inc) w_date = w_dim_month_inc;
    end else if (timeset && date_adv) begin
      w_date = (r_date >= w_dim_cur) ? c_JAN : r_date + 7'd1;
    end else if (timeset && year_adv) begin
      w_phase = w_phase_inc;
      if ((r_month == c_FEB) && (r_date > w_dim_feb_next)) w_date = w_dim_feb_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_date  <= 7'(INIT_DATE);
      r_month <= 7'(INIT_MONTH);
      r_phase <= 2'd0;
      r_ytick <= 1'b0;
    end else begin
      r_date  <= w_date;
      r_month <= w_month;
      r_phase <= w_phase;
      r_ytick <= w_ytick;
    end
  end

  assign TDate     = r_date;
  assign TMonth    = r_month;
  assign yr_phase  = r_phase;
  assign year_tick = r_ytick;

endmodule
`default_nettype wire

// File: doc/calendar_date_month.md
Name: calendar_date_month

Overview:
- Date/month calendar stage downstream of the time-of-day/day-of-week logic.
- Consumes the one-cycle day-rollover enable (the same Dayen that advances the weekday counter) and maintains date (1..31) and month (1..12), with a 4-year leap phase so February has 29 days in leap years.
- Outputs are 7-bit binary values sized to feed the existing 2-digit lcd_int display drivers directly.
- Supports manual date, month and year-phase advance while Timeset is held.

Parameters:
- LEAP_EN, 1, 1 = Feb has 29 days when yr_phase==0; 0 = Feb always 28.
- INIT_MONTH, 1, month loaded on reset (legal range 1..12).
- INIT_DATE, 1, date loaded on reset (legal range 1..days-in-INIT_MONTH).

Ports:
- clk  input  1  system clock (Pulse at top level, 1/sec).
- rst  input  1  asynchronous reset, active-low.
- day_tick  input  1  single-cycle day rollover enable (top-level Dayen).
- timeset  input  1  manual-set mode qualifier.
- date_adv  input  1  advance date by one per enabled cycle while timeset=1.
- month_adv  input  1  advance month by one per enabled cycle while timeset=1.
- year_adv  input  1  advance leap phase by one per enabled cycle while timeset=1.
- TDate  output  7  current date, binary 1..31.
- TMonth  output  7  current month, binary 1..12.
- yr_phase  output  2  years since last leap year (0 = leap year).
- leap  output  1  combinational: LEAP_EN && yr_phase==0.
- year_tick  output  1  registered one-cycle pulse, asserted the cycle after a Dec 31 -> Jan 1 rollover.

Behaviour:
- Reset (rst=0, asynchronous): TDate=INIT_DATE, TMonth=INIT_MONTH, yr_phase=0, year_tick=0. All state updates on posedge clk only while rst=1.
- dim(m), days in month: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; for 2, 29 if leap else 28. Purely combinational from TMonth and leap.
- Priority per cycle: day_tick > month_adv > date_adv > year_adv. Exactly one action per cycle; lower-priority requests that cycle are dropped, not queued.
- Manual inputs act only when timeset=1. day_tick acts regardless of timeset, because hour-advance rollover during set mode must carry.
- Natural advance (day_tick=1):
  - TDate<dim(TMonth): TDate+1.
  - TDate==dim, TMonth<12: TDate=1, TMonth+1.
  - TDate==dim, TMonth==12: TDate=1, TMonth=1, yr_phase+1 (mod 4, 3->0), year_tick=1 next cycle.
- year_tick is high for exactly one cycle and otherwise 0. Back-to-back rollovers are impossible in normal use; if stimulated, each one pulses.
- month_adv (timeset=1, no day_tick):
  - TMonth+1, with 12->1. No carry into yr_phase and no year_tick.
  - Same cycle, TDate is clamped: if TDate>dim(new month), TDate=dim(new month). dim uses the current leap value.
- date_adv (timeset=1, no day_tick, no month_adv): TDate+1, with dim(TMonth)->1. No carry into month.
- year_adv (timeset=1, no other action): yr_phase+1 mod 4.
  - If the new phase makes Feb non-leap and TMonth==2 and TDate==29, TDate clamps to 28 in the same cycle.
- Latency: all outputs update on the clock edge at which the enable is sampled, i.e. visible the next cycle. No pipelining.
- Invariant: 1<=TDate<=dim(TMonth) and 1<=TMonth<=12 at every cycle boundary. No out-of-range state is ever reachable from reset.
- Reset asserted mid-operation overrides any enable in the same cycle. Outputs go to reset values immediately, without waiting for clk.

Test Plan:
- Reset then 31 day_ticks from Jan 1 -> Feb 1; 28 more with yr_phase=1 -> Mar 1. With yr_phase=0, Feb 28 + tick -> Feb 29, then + tick -> Mar 1.
- Dec 31 with yr_phase=3 + day_tick -> TDate=1, TMonth=1, yr_phase=0, year_tick=1 for exactly one cycle, then 0.
- timeset=1, Jan 31 + month_adv -> TMonth=2, TDate=29 if leap else 28. Then date_adv -> TDate=1 and TMonth stays 2.
- timeset=0 with date_adv/month_adv/year_adv pulsed -> no change. Then day_tick and month_adv in the same cycle at Apr 30 with timeset=1 -> May 1 (month_adv dropped).
- Feb 29 with yr_phase=0 + year_adv -> yr_phase=1, TDate=28, leap=0. LEAP_EN=0 build: Feb 28 + tick -> Mar 1 for all phases.
- rst pulled low asynchronously mid-cycle while day_tick=1 at Jun 15 -> TDate=INIT_DATE, TMonth=INIT_MONTH, yr_phase=0 before the next clk edge. Normal counting resumes after release.
